// File: rtl/jtpopeye_obj_dma_pkg.sv
// Shared constants for the Popeye object-RAM DMA: state encoding and default source base.
// The state values are fixed so that a bench or debugger can decode the state register.
package jtpopeye_obj_dma_pkg;

   localparam logic [11:0] SRC_BASE_DEF = 12'hC00;
   localparam int          CNT_W        = 9;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_REQ   = 3'd1,
      ST_COPY  = 3'd2,
      ST_DRAIN = 3'd3,
      ST_REL   = 3'd4
   } state_t;

endpackage

// File: rtl/jtpopeye_obj_dma_if.sv
// Bus bundle between the object DMA and the Z80 bus / CPU RAM / object line buffer RAM.
interface jtpopeye_obj_dma_if #(
   parameter int OBJ_AW = 8
);
   logic              busrq_n;
   logic              busak_n;
   logic [11:0]       ram_addr;
   logic [7:0]        ram_din;
   logic [OBJ_AW-1:0] obj_addr;
   logic [7:0]        obj_dout;
   logic              obj_we;

   modport master (
      output busrq_n, ram_addr, obj_addr, obj_dout, obj_we,
      input  busak_n, ram_din
   );

   modport slave (
      input  busrq_n, ram_addr, obj_addr, obj_dout, obj_we,
      output busak_n, ram_din
   );
endinterface

// File: rtl/jtpopeye_obj_dma.sv
// Object-RAM DMA: on VB rise (when armed) takes the Z80 bus and copies LEN sprite bytes
// from CPU RAM into object RAM, one byte per pixel clock enable, then releases the bus.
//
// state    | meaning
// IDLE     | bus released, waiting for VB rise while armed
// REQ      | busrq_n low, waiting for busak_n
// COPY     | issuing CPU RAM reads, writing the previous byte
// DRAIN    | writing the last byte
// REL      | busrq_n high, waiting for busak_n to return high
module jtpopeye_obj_dma
   import jtpopeye_obj_dma_pkg::*;
#(
   parameter logic [11:0] SRC_BASE = SRC_BASE_DEF,
   parameter int          LEN      = 256,
   parameter int          OBJ_AW   = 8
)(
   input  logic               clk,
   input  logic               rst,
   input  logic               i_pxl_cen,
   input  logic               i_vb,
   input  logic               i_dma_go,
   jtpopeye_obj_dma_if.master bus,
   output logic               o_busy,
   output logic               o_dma_abort
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(LEN - 1);

   state_t             r_state, w_state_nxt;
   logic               r_vbl, r_armed, r_rearm, r_abort;
   logic [CNT_W-1:0]   r_cnt;
   logic [11:0]        r_ram_addr;
   logic [OBJ_AW-1:0]  r_obj_addr, w_cnt_m1;
   logic [7:0]         r_obj_dout;
   logic               r_obj_we;
   logic               w_vb_rise, w_vb_fall, w_abort, w_arm_clr;

   assign w_vb_rise = i_vb & ~r_vbl;
   assign w_vb_fall = ~i_vb & r_vbl;
   assign w_cnt_m1  = OBJ_AW'(r_cnt - CNT_W'(1));

   assign w_abort   = i_pxl_cen & w_vb_fall &
                      (((r_state == ST_REQ) & bus.busak_n) |
                       (r_state == ST_COPY) | (r_state == ST_DRAIN));
   assign w_arm_clr = i_pxl_cen &
                      (((r_state == ST_COPY) & (w_state_nxt != ST_COPY)) |
                       ((r_state == ST_REQ)  & (w_state_nxt == ST_REL)));

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:  if (w_vb_rise && r_armed) w_state_nxt = ST_REQ;
         ST_REQ:   if (!bus.busak_n)         w_state_nxt = ST_COPY;
                   else if (w_vb_fall)       w_state_nxt = ST_REL;
         ST_COPY:  if (w_vb_fall)            w_state_nxt = ST_REL;
                   else if (r_cnt == LAST)   w_state_nxt = ST_DRAIN;
         ST_DRAIN:                           w_state_nxt = ST_REL;
         ST_REL:   if (bus.busak_n)          w_state_nxt = ST_IDLE;
         default:                            w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_vbl   <= 1'b0;
      end else if (i_pxl_cen) begin
         r_state <= w_state_nxt;
         r_vbl   <= i_vb;
      end
   end

   // A dma_go seen mid-transfer survives the clear that happens on leaving COPY.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_armed <= 1'b0;
         r_rearm <= 1'b0;
         r_abort <= 1'b0;
      end else begin
         if (i_dma_go)       r_armed <= 1'b1;
         else if (w_arm_clr) r_armed <= r_rearm;

         if (i_dma_go && r_state != ST_IDLE)       r_rearm <= 1'b1;
         else if (w_arm_clr || r_state == ST_IDLE) r_rearm <= 1'b0;

         if (w_abort)       r_abort <= 1'b1;
         else if (i_dma_go) r_abort <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt      <= '0;
         r_ram_addr <= SRC_BASE;
         r_obj_addr <= '0;
         r_obj_dout <= '0;
         r_obj_we   <= 1'b0;
      end else begin
         r_obj_we <= 1'b0;
         if (i_pxl_cen && !w_abort) begin
            case (r_state)
               ST_REQ: if (!bus.busak_n) r_cnt <= '0;
               ST_COPY: begin
                  r_ram_addr <= SRC_BASE + 12'(r_cnt);
                  if (r_cnt != '0) begin
                     r_obj_addr <= w_cnt_m1;
                     r_obj_dout <= bus.ram_din;
                     r_obj_we   <= 1'b1;
                  end
                  r_cnt <= r_cnt + CNT_W'(1);
               end
               ST_DRAIN: begin
                  r_obj_addr <= w_cnt_m1;
                  r_obj_dout <= bus.ram_din;
                  r_obj_we   <= 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

   assign bus.busrq_n  = ~((r_state == ST_REQ) | (r_state == ST_COPY) | (r_state == ST_DRAIN));
   assign bus.ram_addr = r_ram_addr;
   assign bus.obj_addr = r_obj_addr;
   assign bus.obj_dout = r_obj_dout;
   assign bus.obj_we   = r_obj_we;
   assign o_busy       = (r_state != ST_IDLE);
   assign o_dma_abort  = r_abort;

endmodule

// File: tb/tb_jtpopeye_obj_dma.sv
// Bench for jtpopeye_obj_dma: per-frame scenario table plus hand sequences for
// same-cen arming, abort clearing and reset in the middle of COPY.
module tb_jtpopeye_obj_dma;
   import jtpopeye_obj_dma_pkg::*;

   logic clk, rst, pxl_cen, VB, dma_go, busy, dma_abort;
   jtpopeye_obj_dma_if #(.OBJ_AW(8)) bus();

   jtpopeye_obj_dma #(.SRC_BASE(12'hC00), .LEN(256), .OBJ_AW(8)) dut (
      .clk(clk), .rst(rst), .i_pxl_cen(pxl_cen), .i_vb(VB), .i_dma_go(dma_go),
      .bus(bus), .o_busy(busy), .o_dma_abort(dma_abort)
   );

   function automatic logic [7:0] pat(input logic [11:0] a);
      return a[7:0] * 8'd37 + {4'd0, a[11:8]} * 8'd5 + 8'd11;
   endfunction

   assign bus.ram_din = pat(bus.ram_addr);

   initial begin clk = 0; forever #5 clk = ~clk; end
   initial begin pxl_cen = 0; forever begin @(negedge clk); pxl_cen = ~pxl_cen; end end

   int n_checks = 0, n_errors = 0;
   int wr_count = 0, wide_cnt = 0;
   int hits [256];
   logic [7:0] data_seen [256];
   logic prev_we = 0;

   always @(negedge clk) begin
      if (bus.obj_we) begin
         if (prev_we) wide_cnt++;
         wr_count++;
         hits[bus.obj_addr]++;
         data_seen[bus.obj_addr] = bus.obj_dout;
      end
      prev_we = bus.obj_we;
   end

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic cen_tick();
      do @(posedge clk); while (!pxl_cen);
      #1;
   endtask

   task automatic pulse_go();
      dma_go = 1;
      @(posedge clk); #1;
      dma_go = 0;
   endtask

   // Z80 model: acknowledges `ack` cens after busrq_n falls (never if ack<0), drops ack on release
   int req_cnt;
   task automatic bus_step(input int ack);
      if (bus.busrq_n) begin
         bus.busak_n = 1; req_cnt = 0;
      end else begin
         req_cnt++;
         if (ack >= 0 && req_cnt >= ack) bus.busak_n = 0;
      end
   endtask

   typedef struct {
      bit arm; int ack; int vb; int go_at;
      int exp_wr; bit exp_abort; bit exp_req; bit exp_armed;
   } row_t;

   int f_t_ack, f_t_rel, f_t_we, f_writes, w_wide0;
   bit f_saw_req;
   int hits0 [256];

   task automatic run_frame(input row_t r);
      int w0;
      f_t_ack = -1; f_t_rel = -1; f_t_we = -1; f_saw_req = 0; req_cnt = 0;
      hits0 = hits; w_wide0 = wide_cnt;
      if (r.arm) pulse_go();
      repeat (3) cen_tick();
      w0 = wr_count;
      VB = 1;
      for (int i = 0; i < r.vb + 8; i++) begin
         if (!bus.busak_n && f_t_ack < 0) f_t_ack = i;
         cen_tick();
         if (!bus.busrq_n) f_saw_req = 1;
         if (bus.obj_we && f_t_we < 0) f_t_we = i;
         if (f_t_ack >= 0 && bus.busrq_n && f_t_rel < 0) f_t_rel = i;
         if (i + 1 == r.vb) VB = 0;
         bus_step(r.ack);
         if (i == r.go_at) pulse_go();
      end
      @(negedge clk);
      f_writes = wr_count - w0;
   endtask

   task automatic check_frame(input string tag, input row_t r);
      int bad_hit, bad_data;
      bad_hit = 0; bad_data = 0;
      for (int a = 0; a < 256; a++) begin
         if ((hits[a] - hits0[a]) != ((a < r.exp_wr) ? 1 : 0)) bad_hit++;
         if (a < r.exp_wr && data_seen[a] != pat(12'hC00 + 12'(a))) bad_data++;
      end
      check({tag, " writes"},   f_writes, r.exp_wr);
      check({tag, " abort"},    int'(dma_abort), int'(r.exp_abort));
      check({tag, " saw_req"},  int'(f_saw_req), int'(r.exp_req));
      check({tag, " busy"},     int'(busy), 0);
      check({tag, " busrq_n"},  int'(bus.busrq_n), 1);
      check({tag, " armed"},    int'(dut.r_armed), int'(r.exp_armed));
      check({tag, " addr_cov"}, bad_hit, 0);
      check({tag, " data"},     bad_data, 0);
      check({tag, " we_width"}, wide_cnt - w_wide0, 0);
      if (r.exp_wr > 0) check({tag, " first_we"}, f_t_we - f_t_ack, 2);
      if (r.exp_wr == 256) check({tag, " latency"}, f_t_rel - f_t_ack, 257);
   endtask

   row_t rows [7];
   row_t r_tmp;

   initial begin
      int w0;
      //           arm ack  vb   go  wr   abrt req armed
      rows[0] = '{0,   3,   40,  -1, 0,   0,   0,  0};   // no dma_go: nothing happens
      rows[1] = '{1,   3,   300, -1, 256, 0,   1,  0};   // full transfer
      rows[2] = '{1,   -1,  20,  -1, 0,   1,   1,  0};   // bus never granted
      rows[3] = '{1,   3,   104, -1, 99,  1,   1,  0};   // VB falls at cnt=100
      rows[4] = '{1,   5,   300, -1, 256, 0,   1,  0};   // slower ack, abort cleared by dma_go
      rows[5] = '{1,   3,   300, 50, 256, 0,   1,  1};   // dma_go during COPY re-arms
      rows[6] = '{0,   3,   300, -1, 256, 0,   1,  0};   // second transfer from that re-arm

      rst = 1; VB = 0; dma_go = 0; bus.busak_n = 1;
      repeat (3) @(posedge clk); #1;
      check("rst busrq_n",  int'(bus.busrq_n), 1);
      check("rst busy",     int'(busy), 0);
      check("rst obj_we",   int'(bus.obj_we), 0);
      check("rst abort",    int'(dma_abort), 0);
      check("rst ram_addr", int'(bus.ram_addr), 'hC00);
      check("rst obj_addr", int'(bus.obj_addr), 0);
      check("rst obj_dout", int'(bus.obj_dout), 0);
      check("rst armed",    int'(dut.r_armed), 0);
      rst = 0;

      for (int k = 0; k < 7; k++) begin
         run_frame(rows[k]);
         check_frame($sformatf("row%0d", k), rows[k]);
      end

      // dma_go on the same cen as vb_rise while disarmed: arms, does not start
      cen_tick();
      @(posedge clk); #1;
      VB = 1; dma_go = 1;
      @(posedge clk); #1;
      dma_go = 0;
      check("same_cen busrq_n", int'(bus.busrq_n), 1);
      check("same_cen armed",   int'(dut.r_armed), 1);
      repeat (3) cen_tick();
      check("same_cen busy", int'(busy), 0);
      VB = 0;
      repeat (3) cen_tick();

      // armed, bus never granted: abort; then dma_go clears the flag
      r_tmp = '{0, -1, 20, -1, 0, 1, 1, 0};
      run_frame(r_tmp);
      check_frame("noack", r_tmp);
      pulse_go();
      check("go_clr abort", int'(dma_abort), 0);
      check("go_clr armed", int'(dut.r_armed), 1);

      // reset in the middle of COPY
      repeat (3) cen_tick();
      req_cnt = 0; w0 = wr_count;
      VB = 1;
      for (int i = 0; i < 54; i++) begin
         cen_tick();
         bus_step(3);
      end
      check("mid cnt",    int'(dut.r_cnt), 50);
      check("mid obj_we", int'(bus.obj_we), 1);
      rst = 1; #1;
      check("rstmid busrq_n", int'(bus.busrq_n), 1);
      check("rstmid busy",    int'(busy), 0);
      check("rstmid obj_we",  int'(bus.obj_we), 0);
      check("rstmid armed",   int'(dut.r_armed), 0);
      VB = 0; bus.busak_n = 1;
      repeat (3) @(posedge clk); #1;
      rst = 0;
      @(negedge clk);
      // the pulse for byte 48 was cleared by reset before the monitor could see it
      check("rstmid writes", wr_count - w0, 48);
      r_tmp = '{0, 3, 40, -1, 0, 0, 0, 0};
      run_frame(r_tmp);
      check_frame("after_rst", r_tmp);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/jtpopeye_obj_dma.md
# jtpopeye_obj_dma

Object-RAM DMA controller for the Popeye video subsystem. On the rising edge of vertical blank, if the CPU has armed it, it takes the main CPU bus with a BUSRQ/BUSAK handshake. It then copies a block of sprite attribute bytes from CPU work RAM into the object line buffer RAM, paced by the pixel clock enable, and releases the bus. It sits between the timing generator (VB source), the Z80 bus interface and the object engine.

## Interface
Parameters:
- SRC_BASE, 12'hC00: CPU RAM word address of first sprite byte.
- LEN, 256: bytes per transfer, 2..256.
- OBJ_AW, 8: object RAM address width; LEN ≤ 2**OBJ_AW.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- pxl_cen  in  1  pixel clock enable; all FSM steps occur on clk edges with pxl_cen=1.
- VB  in  1  vertical blank from the timing block.
- dma_go  in  1  one-clk strobe from the CPU register write; arms a transfer.
- busak_n  in  1  Z80 bus acknowledge, active-low.
- ram_din  in  8  CPU RAM read data, valid one pxl_cen after ram_addr.
- busrq_n  out  1  Z80 bus request, active-low.
- ram_addr  out  12  CPU RAM address = SRC_BASE + cnt.
- obj_addr  out  OBJ_AW  object RAM write address.
- obj_dout  out  8  object RAM write data.
- obj_we  out  1  object RAM write strobe, exactly one clk wide.
- busy  out  1  high in any state other than IDLE.
- dma_abort  out  1  sticky flag; a transfer was cut short by VB falling.

## Operation
- `armed` is set by dma_go on any clk. dma_go also clears dma_abort. `armed` is cleared when a transfer leaves COPY, whether it finished or aborted.
- VB edge detect: VBl is a register updated on pxl_cen. vb_rise = VB & ~VBl; vb_fall = ~VB & VBl.
- States:
  - IDLE: busrq_n=1. On vb_rise with armed, go to REQ.
  - REQ: busrq_n=0. If busak_n=0, go to COPY with cnt=0. If vb_fall occurs first, set dma_abort, clear armed and go to REL.
  - COPY: on each cen, ram_addr is set to SRC_BASE+cnt. If cnt>0, the byte for cnt-1 is written (obj_addr=cnt-1, obj_dout=ram_din, obj_we=1). cnt then increments. After cnt=LEN-1 is issued, go to DRAIN.
  - DRAIN: one cen. Writes byte LEN-1 and goes to REL.
  - REL: busrq_n=1. When busak_n=1, go to IDLE.
- A vb_fall in COPY or DRAIN sets dma_abort, clears armed and goes to REL. Writes already done are kept.
- If dma_go arrives while busy, it re-arms for the next VB. It does not restart the current transfer.
- cnt is 9 bits. It must not wrap: LEN=256 ends at cnt=255.

## Timing
- Reset values:
  - busrq_n=1, busy=0, obj_we=0, dma_abort=0.
  - ram_addr=SRC_BASE, obj_addr=0, obj_dout=0.
  - armed=0, state=IDLE, VBl=0.
- busrq_n falls on the same clk edge as the vb_rise cen.
- First obj_we occurs on the second COPY cen.
- Cen counts from busak_n=0 to the last obj_we:
  - COPY: LEN cens.
  - DRAIN: 1 cen.
  - Total: LEN+1 cens.
- busrq_n rises on the cen that enters REL.
- busy falls on the cen where busak_n=1 is sampled in REL.
- busak_n is sampled only on pxl_cen.
- If vb_rise and dma_go occur on the same cen while not armed, the transfer is not started.
- rst mid-transfer immediately releases busrq_n with no drain write.

## Structure
- The state encoding (IDLE=0, REQ=1, COPY=2, DRAIN=3, REL=4) and the SRC_BASE default belong as localparams in the shared jtpopeye constants include, so the bench can decode state.
- Single flat module. No sub-module is warranted; the edge detector is two flops.

## Test plan
- dma_go, then VB rises and busak_n falls 3 cens later, LEN=256 -> 256 obj_we pulses, obj_addr 0..255 each once, obj_dout equals the RAM model at 0xC00+addr, busrq_n high after 257 COPY+DRAIN cens.
- VB rises without dma_go -> busrq_n stays 1 for the whole frame, no obj_we.
- busak_n held high all of VB -> at vb_fall, dma_abort=1, busrq_n=1, no obj_we; the next dma_go clears dma_abort.
- VB falls at cnt=100 in COPY -> exactly 99 writes (addr 0..98), then REL, dma_abort=1, armed=0.
- dma_go during COPY -> the current transfer completes normally; the next vb_rise starts a second full transfer.
- rst asserted in COPY at cnt=50 -> on the same edge busrq_n=1, busy=0, obj_we=0; no transfer on the following VB unless re-armed.
